// File: rtl/light_ctrl_pkg.sv
// Shared encodings for the tail-light control path: mode/state values used by the
// mode controller, the hazard flasher and the turn-signal sequencers.
package light_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_LEFT   = 2'd1,
        ST_RIGHT  = 2'd2,
        ST_HAZARD = 2'd3
    } state_t;

    function automatic logic is_turn(input state_t s);
        return (s == ST_LEFT) || (s == ST_RIGHT);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One push-button conditioner: 2-FF synchroniser, stability counter and a registered
// one-cycle pulse on each debounced rising edge.
module sw_debounce #(
    parameter int DEB_CYCLES = 16,
    parameter int DEB_W      = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic             sync1;
    logic             sync2;
    logic [DEB_W-1:0] cnt;
    logic             level;
    logic             level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // The level only moves after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/signal_mode_ctrl.sv
// Tail-light mode controller: debounces the hazard/left/right buttons and runs the
// IDLE/LEFT/RIGHT/HAZARD mode FSM. Define AUTO_CANCEL_EN to add the turn auto-cancel timer.
module signal_mode_ctrl
    import light_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES     = 16,
    parameter int DEB_W          = 5,
    parameter int TIMEOUT_CYCLES = 4000,
    parameter int TO_W           = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_haz,
    input  logic              btn_left,
    input  logic              btn_right,
    output logic              haz_ena,
    output logic              left_ena,
    output logic              right_ena,
    output logic [MODE_W-1:0] mode
);

    logic   press_haz;
    logic   press_left;
    logic   press_right;
    logic   timeout;
    state_t state_q;
    state_t state_d;

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_haz (
        .clk(clk), .rst_n(rst_n), .btn(btn_haz), .press(press_haz)
    );

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_left (
        .clk(clk), .rst_n(rst_n), .btn(btn_left), .press(press_left)
    );

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_right (
        .clk(clk), .rst_n(rst_n), .btn(btn_right), .press(press_right)
    );

`ifdef AUTO_CANCEL_EN
    logic [TO_W-1:0] timer_q;

    // Restarts on every entry into a turn state, so LEFT<->RIGHT gets a fresh interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (is_turn(state_d) && (state_d != state_q)) begin
            timer_q <= '0;
        end else if (is_turn(state_q)) begin
            timer_q <= timer_q + 1'b1;
        end else begin
            timer_q <= '0;
        end
    end

    assign timeout = is_turn(state_q) && (timer_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Hazard outranks everything; a simultaneous left+right press is a no-op.
    always_comb begin
        state_d = state_q;
        if (press_haz) begin
            state_d = (state_q == ST_HAZARD) ? ST_IDLE : ST_HAZARD;
        end else if (press_left && press_right) begin
            state_d = state_q;
        end else if (press_left) begin
            case (state_q)
                ST_IDLE, ST_RIGHT: state_d = ST_LEFT;
                ST_LEFT:           state_d = ST_IDLE;
                default:           state_d = state_q;
            endcase
        end else if (press_right) begin
            case (state_q)
                ST_IDLE, ST_LEFT: state_d = ST_RIGHT;
                ST_RIGHT:         state_d = ST_IDLE;
                default:          state_d = state_q;
            endcase
        end else if (timeout) begin
            state_d = ST_IDLE;
        end
    end

    assign haz_ena   = (state_q == ST_HAZARD);
    assign left_ena  = (state_q == ST_LEFT);
    assign right_ena = (state_q == ST_RIGHT);
    assign mode      = state_q;

endmodule

// File: tb/tb_signal_mode_ctrl.sv
// Bench for signal_mode_ctrl: directed scenarios plus random button activity, checked
// against a cycle-level behavioural model of the button/mode rules.
module tb_signal_mode_ctrl;

    localparam int DEB     = 16;
    localparam int TIMEOUT = 4000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_haz = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       haz_ena;
    logic       left_ena;
    logic       right_ena;
    logic [1:0] mode;

    int vectors = 0;
    int miscompares = 0;

    signal_mode_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .btn_haz(btn_haz), .btn_left(btn_left), .btn_right(btn_right),
        .haz_ena(haz_ena), .left_ena(left_ena), .right_ena(right_ena),
        .mode(mode)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Buttons indexed 0=haz 1=left 2=right. A raw value seen at an edge is compared two
    // edges later; a debounced level flips once DEB consecutive compared samples
    // disagree with it; the resulting press acts on the mode two edges after that.
    int       m_mode;
    int       m_dwell;
    int       m_run[3];
    bit [2:0] m_lvl, m_d1, m_d2, m_ev1, m_ev2;
    bit [2:0] m_raw, m_cmp, m_now, m_act;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_dwell = 0;
            m_lvl = '0; m_d1 = '0; m_d2 = '0; m_ev1 = '0; m_ev2 = '0;
            for (int b = 0; b < 3; b++) m_run[b] = 0;
        end else begin
            m_raw = {btn_right, btn_left, btn_haz};
            m_cmp = m_d2; m_d2 = m_d1; m_d1 = m_raw;
            m_act = m_ev2; m_ev2 = m_ev1;
            m_now = '0;
            for (int b = 0; b < 3; b++) begin
                m_run[b] = (m_cmp[b] != m_lvl[b]) ? m_run[b] + 1 : 0;
                if (m_run[b] == DEB) begin
                    m_lvl[b] = m_cmp[b];
                    m_run[b] = 0;
                    m_now[b] = m_cmp[b];
                end
            end
            m_ev1 = m_now;
            apply_model(m_act);
        end
    end

    function automatic void apply_model(input bit [2:0] p);
        int prev = m_mode;
        bit acted = 1'b1;
        if (p[0])                m_mode = (m_mode == 3) ? 0 : 3;
        else if (p[1] && p[2])   acted = 1'b1;
        else if (p[1])           begin if (m_mode != 3) m_mode = (m_mode == 1) ? 0 : 1; end
        else if (p[2])           begin if (m_mode != 3) m_mode = (m_mode == 2) ? 0 : 2; end
        else                     acted = 1'b0;
`ifdef AUTO_CANCEL_EN
        if (!acted && (m_mode == 1 || m_mode == 2) && m_dwell == TIMEOUT - 1) m_mode = 0;
        else if ((m_mode == 1 || m_mode == 2) && m_mode != prev) m_dwell = 0;
        else if (m_mode == 1 || m_mode == 2) m_dwell++;
        else m_dwell = 0;
`else
        if (acted || prev >= 0) m_dwell = 0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; btn_haz = 0; btn_left = 0; btn_right = 0;
        run_cycles(3);
        rst_n = 1'b1;
        run_cycles(3);
    endtask

    task automatic press_btn(input int b, input int hold, input int gap);
        if (b == 0) btn_haz = 1'b1; else if (b == 1) btn_left = 1'b1; else btn_right = 1'b1;
        run_cycles(hold);
        btn_haz = 0; btn_left = 0; btn_right = 0;
        run_cycles(gap);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            btn_haz = 1'($urandom); btn_left = 1'($urandom); btn_right = 1'($urandom);
            @(negedge clk);
            vectors++;
            if ({haz_ena, left_ena, right_ena, mode} !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_hold: outputs=%b required=00000", {haz_ena, left_ena, right_ena, mode});
            end
        end
        btn_haz = 0; btn_left = 0; btn_right = 0;
        rst_n = 1'b1;
        run_cycles(30);
        vectors++;
        if (mode !== 2'd0 || haz_ena !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: mode=%0d required=0", mode);
        end
    endtask

    task automatic test_hazard_latency();
        btn_haz = 1'b1;                 // first edge after this is edge 0
        run_cycles(DEB + 3);            // sampled just after edge DEB+2
        vectors++;
        if (mode !== 2'd0 || haz_ena !== 1'b0) begin
            miscompares++;
            $display("FAIL haz_early: mode=%0d haz_ena=%b required mode=0 haz_ena=0", mode, haz_ena);
        end
        run_cycles(1);                  // just after edge DEB+3
        vectors++;
        if (mode !== 2'd3 || haz_ena !== 1'b1 || left_ena !== 1'b0 || right_ena !== 1'b0) begin
            miscompares++;
            $display("FAIL haz_on: mode=%0d haz_ena=%b required mode=3 haz_ena=1", mode, haz_ena);
        end
        run_cycles(40 - DEB - 4);
        btn_haz = 1'b0;
        run_cycles(40);
        vectors++;
        if (mode !== 2'd3) begin
            miscompares++;
            $display("FAIL haz_release: mode=%0d required=3", mode);
        end
        press_btn(0, 40, 30);
        vectors++;
        if (mode !== 2'd0 || haz_ena !== 1'b0) begin
            miscompares++;
            $display("FAIL haz_off: mode=%0d required=0", mode);
        end
    endtask

    task automatic test_glitch_and_turns();
        for (int i = 0; i < 4; i++) press_btn(1, 10, 12);
        vectors++;
        if (mode !== 2'd0 || left_ena !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_left: mode=%0d required=0", mode);
        end
        press_btn(1, 30, 30);
        vectors++;
        if (mode !== 2'd1 || left_ena !== 1'b1) begin
            miscompares++;
            $display("FAIL clean_left: mode=%0d left_ena=%b required mode=1 left_ena=1", mode, left_ena);
        end
        press_btn(2, 30, 30);
        vectors++;
        if (mode !== 2'd2 || right_ena !== 1'b1 || left_ena !== 1'b0) begin
            miscompares++;
            $display("FAIL left_to_right: mode=%0d right_ena=%b left_ena=%b required 2/1/0", mode, right_ena, left_ena);
        end
        press_btn(2, 30, 30);
        vectors++;
        if (mode !== 2'd0 || right_ena !== 1'b0) begin
            miscompares++;
            $display("FAIL right_cancel: mode=%0d required=0", mode);
        end
    endtask

    task automatic test_haz_priority();
        do_reset();
        btn_haz = 1'b1; btn_left = 1'b1;
        run_cycles(30);
        btn_haz = 1'b0; btn_left = 1'b0;
        run_cycles(30);
        vectors++;
        if (mode !== 2'd3 || left_ena !== 1'b0) begin
            miscompares++;
            $display("FAIL haz_left_same: mode=%0d required=3", mode);
        end
        press_btn(1, 30, 30);
        vectors++;
        if (mode !== 2'd3 || haz_ena !== 1'b1) begin
            miscompares++;
            $display("FAIL left_in_haz: mode=%0d required=3", mode);
        end
    endtask

    task automatic test_left_right_and_reset();
        do_reset();
        btn_left = 1'b1; btn_right = 1'b1;
        run_cycles(30);
        btn_left = 1'b0; btn_right = 1'b0;
        run_cycles(30);
        vectors++;
        if (mode !== 2'd0 || left_ena !== 1'b0 || right_ena !== 1'b0) begin
            miscompares++;
            $display("FAIL left_right_same: mode=%0d required=0", mode);
        end
        press_btn(1, 30, 30);
        vectors++;
        if (mode !== 2'd1) begin
            miscompares++;
            $display("FAIL enter_left: mode=%0d required=1", mode);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (mode !== 2'd0 || left_ena !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: mode=%0d left_ena=%b required 0/0", mode, left_ena);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(3);
    endtask

    task automatic test_timeout();
        do_reset();
        btn_left = 1'b1;                // LEFT is entered at edge DEB+3
        run_cycles(30);
        btn_left = 1'b0;
`ifdef AUTO_CANCEL_EN
        run_cycles(DEB + 3 + TIMEOUT - 30);   // just after edge DEB+2+TIMEOUT
        vectors++;
        if (mode !== 2'd1) begin
            miscompares++;
            $display("FAIL before_timeout: mode=%0d required=1", mode);
        end
        run_cycles(1);
        vectors++;
        if (mode !== 2'd0 || left_ena !== 1'b0) begin
            miscompares++;
            $display("FAIL auto_cancel: mode=%0d required=0", mode);
        end
`else
        run_cycles(10000 - 30);
        vectors++;
        if (mode !== 2'd1 || left_ena !== 1'b1) begin
            miscompares++;
            $display("FAIL no_timeout: mode=%0d required=1", mode);
        end
`endif
    endtask

    task automatic test_random();
        int hold[3];
        bit [2:0] lv;
        do_reset();
        for (int b = 0; b < 3; b++) hold[b] = 0;
        lv = '0;
        for (int c = 0; c < 2500; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    lv[b]   = ($urandom_range(0, 3) == 0);
                    hold[b] = lv[b] ? $urandom_range(1, 40) : $urandom_range(5, 80);
                end else begin
                    hold[b]--;
                end
            end
            btn_haz = lv[0]; btn_left = lv[1]; btn_right = lv[2];
            @(negedge clk);
            vectors++;
            if (mode !== 2'(m_mode) || haz_ena !== (m_mode == 3) ||
                left_ena !== (m_mode == 1) || right_ena !== (m_mode == 2)) begin
                miscompares++;
                $display("FAIL random_cycle%0d: mode=%0d ena=%b%b%b required mode=%0d",
                         c, mode, haz_ena, left_ena, right_ena, m_mode);
            end
        end
        btn_haz = 0; btn_left = 0; btn_right = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_hazard_latency();
        test_glitch_and_turns();
        test_haz_priority();
        test_left_right_and_reset();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
